fsk_phase_accumulator: RTL and testbench
========================================

FSK_PHASE_ACCUMULATOR -- requirements
Module: fsk_phase_accumulator

Interface
REQ-001 Parameter FREQ_WORD0, default 25'h0020000: phase increment per sample for bit 0.
REQ-002 Parameter FREQ_WORD1, default 25'h0040000: phase increment per sample for bit 1.
REQ-003 Parameter SAMPLES_PER_SYM, default 8, legal range 2..65535: samples per symbol.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port tx_en, input, 1: transmit enable; low forces IDLE.
REQ-007 Port sample_en, input, 1: one-cycle sample strobe at the DAC rate.
REQ-008 Port sym_valid, input, 1: upstream offers a symbol.
REQ-009 Port sym_bit, input, 1: the offered FSK bit.
REQ-010 Port sym_ready, output, 1: symbol accepted this cycle when high with sym_valid.
REQ-011 Port angle, output, `PRECISION: registered phase fed directly to the cosine LUT stage.
REQ-012 Port angle_valid, output, 1: angle is a live sample.
REQ-013 Port cur_bit, output, 1: the bit currently being modulated.
REQ-014 Port sym_done, output, 1: one-cycle pulse on the final sample of each symbol.

Function
REQ-015 The FSM SHALL have two states only: IDLE and RUN.
REQ-016 In IDLE, sym_ready SHALL equal tx_en; on handshake: cur_bit<=sym_bit, sample_cnt<=0, state<=RUN.
REQ-017 In RUN, on each sample_en: phase<=phase+FREQ_WORD(cur_bit), sample_cnt<=sample_cnt+1.
REQ-018 Phase arithmetic SHALL be unsigned, `PRECISION bits, wrapping modulo 2^`PRECISION with no saturation.
REQ-019 angle SHALL be the phase register; it updates on the cycle after sample_en (latency 1).
REQ-020 angle_valid SHALL be high exactly when state is RUN.
REQ-021 On sample_en with sample_cnt==SAMPLES_PER_SYM-1: sym_done=1 and sym_ready=tx_en (combinational, same cycle).
REQ-022 If a symbol is accepted per REQ-021: load cur_bit, set sample_cnt<=0 and stay in RUN; phase SHALL NOT reset (phase continuity across symbols).
REQ-023 If no symbol is accepted per REQ-021: go to IDLE and keep the phase value, so the next burst continues phase-continuously.
REQ-024 In RUN, sym_ready SHALL be 0 except in the REQ-021 cycle.
REQ-025 sample_en low SHALL freeze phase, sample_cnt and state. The only exception is the IDLE handshake.
REQ-026 tx_en low in any state SHALL force IDLE and phase<=0 next cycle, aborting any partial symbol without a sym_done pulse.
REQ-027 sym_valid without sym_ready SHALL cause no state change; sym_bit may change freely while not accepted.

Reset
REQ-028 While reset is high: state=IDLE, phase=0, sample_cnt=0, cur_bit=0, angle=0, angle_valid=0, sym_done=0, sym_ready=0.
REQ-029 Reset SHALL take priority over tx_en, sample_en and any handshake in the same cycle.

Structure
REQ-030 `PRECISION SHALL come from LoRaTXDefines.v. New defines FSK_FREQ_WORD0/1 and FSK_SAMPLES_PER_SYM belong in the same file as the parameter defaults.
REQ-031 sample_cnt SHALL be sized $clog2(SAMPLES_PER_SYM) bits.
REQ-032 One sub-module is natural: phase_acc (enable, increment, clear -> registered `PRECISION-bit phase). The FSM and counter stay in the top level.

Verification (PRECISION=25, defaults, sample_en every 4th cycle)
REQ-033 Single symbol: tx_en=1, sym_bit=1 accepted -> 8 samples, angle 0x40000..0x200000 in steps of 0x40000, sym_done on the 8th sample, then IDLE with angle_valid=0.
REQ-034 Back-to-back bits 0,1: the second symbol is accepted on the first symbol's sym_done cycle -> angle continues 0x100000, 0x140000, ... with no gap and angle_valid held high.
REQ-035 Wrap: FREQ_WORD1=25'h1000000, 3 samples -> angle 0x1000000, 0x0000000, 0x1000000.
REQ-036 Abort: tx_en dropped after sample 3 -> next cycle IDLE, angle=0, no sym_done, sym_ready=0.
REQ-037 Reset mid-RUN, asserted in the same cycle as sample_en -> all outputs match REQ-028 on the next cycle and the increment is discarded.
REQ-038 Stall: sym_valid held high with sample_en=0 for 20 cycles in RUN -> angle constant, sym_ready=0 throughout.

Source files
------------

// File: rtl/fsk_phase_accumulator_pkg.sv
// Shared constants and types for the FSK phase accumulator.
package fsk_phase_accumulator_pkg;

    // Phase / LUT address width used across the TX path.
    localparam int PRECISION = 25;

    // Default tone increments and symbol length.
    localparam logic [PRECISION-1:0] FSK_FREQ_WORD0      = 25'h0020000;
    localparam logic [PRECISION-1:0] FSK_FREQ_WORD1      = 25'h0040000;
    localparam int                   FSK_SAMPLES_PER_SYM = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsk_state_e;

endpackage

// File: rtl/fsk_phase_accumulator_phase_acc.sv
// Registered PRECISION-bit phase accumulator with clear and enable.
module fsk_phase_accumulator_phase_acc
    import fsk_phase_accumulator_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [PRECISION-1:0] inc,
    output logic [PRECISION-1:0] phase
);

    // Unsigned wrap-around accumulate; reset and clear both zero the phase.
    always_ff @(posedge clk) begin
        if (reset || clr)
            phase <= '0;
        else if (en)
            phase <= phase + inc;
    end

endmodule

// File: rtl/fsk_phase_accumulator.sv
// Two-tone FSK phase generator: symbol handshake, per-symbol sample count,
// and a phase-continuous accumulator feeding the cosine LUT.
module fsk_phase_accumulator
    import fsk_phase_accumulator_pkg::*;
#(
    parameter logic [PRECISION-1:0] FREQ_WORD0      = FSK_FREQ_WORD0,
    parameter logic [PRECISION-1:0] FREQ_WORD1      = FSK_FREQ_WORD1,
    parameter int                   SAMPLES_PER_SYM = FSK_SAMPLES_PER_SYM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 sample_en,
    input  logic                 sym_valid,
    input  logic                 sym_bit,
    output logic                 sym_ready,
    output logic [PRECISION-1:0] angle,
    output logic                 angle_valid,
    output logic                 cur_bit,
    output logic                 sym_done
);

    localparam int CW = $clog2(SAMPLES_PER_SYM);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_SYM - 1);

    fsk_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic          last;
    logic          acc_en;

    // Next state, counter and handshake outputs; reset masks the handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sym_ready = 1'b0;
        sym_done  = 1'b0;
        acc_en    = 1'b0;
        last      = sample_en && (cnt_q == CNT_LAST);
        if (!tx_en) begin
            // Abort: partial symbol is dropped silently.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    sym_ready = 1'b1;
                    if (sym_valid) begin
                        state_d = RUN;
                        bit_d   = sym_bit;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (sample_en) begin
                        acc_en = 1'b1;
                        if (last) begin
                            sym_done  = 1'b1;
                            sym_ready = 1'b1;
                            cnt_d     = '0;
                            if (sym_valid)
                                bit_d = sym_bit;
                            else
                                state_d = IDLE; // phase is kept for the next burst
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, sample counter and current bit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    fsk_phase_accumulator_phase_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (!tx_en),
        .en    (acc_en),
        .inc   (bit_q ? FREQ_WORD1 : FREQ_WORD0),
        .phase (angle)
    );

    assign angle_valid = (state_q == RUN);
    assign cur_bit     = bit_q;

endmodule

// File: tb/tb_fsk_phase_accumulator.sv
// Directed bench: single symbol, back-to-back, wrap, abort, reset, stall.
module tb_fsk_phase_accumulator;
    import fsk_phase_accumulator_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1, tx_en = 1'b0, sample_en = 1'b0, sym_valid = 1'b0, sym_bit = 1'b0;
    logic sym_ready, angle_valid, cur_bit, sym_done;
    logic [PRECISION-1:0] angle;
    logic sym_ready_w, angle_valid_w, cur_bit_w, sym_done_w;
    logic [PRECISION-1:0] angle_w;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fsk_phase_accumulator dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .sample_en(sample_en),
        .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_ready(sym_ready),
        .angle(angle), .angle_valid(angle_valid), .cur_bit(cur_bit), .sym_done(sym_done)
    );

    // Same stimulus, large tone-1 increment to exercise the modulo wrap.
    fsk_phase_accumulator #(.FREQ_WORD1(25'h1000000)) dut_w (
        .clk(clk), .reset(reset), .tx_en(tx_en), .sample_en(sample_en),
        .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_ready(sym_ready_w),
        .angle(angle_w), .angle_valid(angle_valid_w), .cur_bit(cur_bit_w), .sym_done(sym_done_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three idle cycles, matching a strobe every 4th cycle.
    task automatic gap();
        sample_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_en = 1'b0;
        sym_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Offer a symbol from IDLE and take it on the next edge.
    task automatic accept(input logic b);
        sym_valid = 1'b1;
        sym_bit = b;
        #1;
        chk("hs_ready", sym_ready, 1);
        tick();
        sym_valid = 1'b0;
        chk("hs_valid", angle_valid, 1);
        chk("hs_bit", cur_bit, b);
    endtask

    initial begin
        // Reset priority: tx_en and a pending symbol are ignored while reset is high.
        tx_en = 1'b1; sym_valid = 1'b1; sym_bit = 1'b1; sample_en = 1'b1;
        tick(); tick();
        chk("rst_ready", sym_ready, 0);
        chk("rst_done", sym_done, 0);
        chk("rst_angle", angle, 0);
        chk("rst_valid", angle_valid, 0);
        chk("rst_bit", cur_bit, 0);
        reset = 1'b0; sym_valid = 1'b0; sample_en = 1'b0;

        // Single bit-1 symbol, 8 samples; wrap instance checked on the first 3.
        accept(1'b1);
        chk("s1_angle0", angle, 0);
        for (int i = 1; i <= 8; i++) begin
            gap();
            sample_en = 1'b1;
            #1;
            chk("s1_done", sym_done, (i == 8));
            chk("s1_ready", sym_ready, (i == 8));
            tick();
            sample_en = 1'b0;
            chk("s1_angle", angle, i * 32'h40000);
            if (i <= 3)
                chk("wrap_angle", angle_w, (i % 2 == 1) ? 32'h1000000 : 32'h0);
        end
        chk("s1_idle", angle_valid, 0);
        chk("s1_hold", angle, 32'h200000);

        // Back-to-back 0 then 1, second accepted on the first sym_done.
        do_reset();
        accept(1'b0);
        for (int i = 1; i <= 8; i++) begin
            gap();
            chk("b2b_v0", angle_valid, 1);
            sample_en = 1'b1;
            if (i == 8) begin sym_valid = 1'b1; sym_bit = 1'b1; end
            #1;
            if (i == 8) begin
                chk("b2b_done", sym_done, 1);
                chk("b2b_ready", sym_ready, 1);
            end
            tick();
            sample_en = 1'b0; sym_valid = 1'b0;
            chk("b2b_a0", angle, i * 32'h20000);
        end
        chk("b2b_v", angle_valid, 1);
        chk("b2b_bit", cur_bit, 1);
        for (int i = 1; i <= 8; i++) begin
            gap();
            chk("b2b_v1", angle_valid, 1);
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            chk("b2b_a1", angle, 32'h100000 + i * 32'h40000);
        end
        chk("b2b_end", angle_valid, 0);

        // Abort after 3 samples.
        do_reset();
        accept(1'b1);
        for (int i = 1; i <= 3; i++) begin
            gap();
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
        end
        chk("ab_pre", angle, 32'hC0000);
        tx_en = 1'b0;
        sym_valid = 1'b1;
        #1;
        chk("ab_ready0", sym_ready, 0);
        chk("ab_done0", sym_done, 0);
        tick();
        chk("ab_valid", angle_valid, 0);
        chk("ab_angle", angle, 0);
        chk("ab_done", sym_done, 0);
        chk("ab_ready", sym_ready, 0);
        sym_valid = 1'b0;
        tx_en = 1'b1;

        // Reset in the same cycle as a sample strobe.
        do_reset();
        accept(1'b1);
        for (int i = 1; i <= 2; i++) begin
            gap();
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
        end
        chk("mr_pre", angle, 32'h80000);
        gap();
        sample_en = 1'b1;
        reset = 1'b1;
        tick();
        chk("mr_angle", angle, 0);
        chk("mr_valid", angle_valid, 0);
        chk("mr_bit", cur_bit, 0);
        chk("mr_ready", sym_ready, 0);
        chk("mr_done", sym_done, 0);
        reset = 1'b0;
        sample_en = 1'b0;

        // Stall: sym_valid high without strobes, bit toggling.
        accept(1'b0);
        gap();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        sym_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sym_bit = i[0];
            #1;
            chk("st_ready", sym_ready, 0);
            tick();
            chk("st_angle", angle, 32'h20000);
        end
        sym_valid = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("st_bit", cur_bit, 0);
        chk("st_next", angle, 32'h40000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
